// File: rtl/row_buffer_seq_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolution row-buffer sequencer.
package row_buffer_seq_pkg;

    localparam int unsigned C_MAX_WIDTH = 320;
    localparam int unsigned C_KERNEL    = 3;
    localparam int unsigned C_DW        = 9;

    // Row widths used by the network layers.
    localparam int unsigned C_WIDTH_L0 = 320;
    localparam int unsigned C_WIDTH_L1 = 80;
    localparam int unsigned C_WIDTH_L2 = 40;
    localparam int unsigned C_WIDTH_L3 = 20;
    localparam int unsigned C_WIDTH_L4 = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPrime,
        StRun,
        StDone
    } state_t;

endpackage

// File: rtl/row_buffer_seq_row_col_counter.sv
// Column/row raster counter with wrap at the programmed width and a last-pixel flag.
module row_col_counter #(
    parameter int unsigned DW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [DW-1:0] i_width,
    input  logic [DW-1:0] i_height,
    output logic [DW-1:0] o_col,
    output logic [DW-1:0] o_row,
    output logic          o_col_wrap,
    output logic          o_last
);

    logic [DW-1:0] r_col;
    logic [DW-1:0] r_row;

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_col_wrap = (r_col == i_width - DW'(1));
    assign o_last     = o_col_wrap && (r_row == i_height - DW'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (o_col_wrap) begin
                r_col <= '0;
                r_row <= o_last ? '0 : r_row + DW'(1);
            end else begin
                r_col <= r_col + DW'(1);
            end
        end
    end

endmodule

// File: rtl/row_buffer_seq.sv
// Frame sequencer: configures row-buffer length, gates pixel shifting and flags valid 3x3 windows.
module row_buffer_seq
    import row_buffer_seq_pkg::*;
#(
    parameter int unsigned MAX_WIDTH = C_MAX_WIDTH,
    parameter int unsigned KERNEL    = C_KERNEL,
    parameter int unsigned DW        = C_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [DW-1:0] i_cfg_width,
    input  logic [DW-1:0] i_cfg_height,
    output logic          o_cfg_err,
    input  logic          i_abort,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic          i_m_ready,
    output logic [DW-1:0] o_buff_len_ctrl,
    output logic          o_buff_len_rst,
    output logic          o_shift_en,
    output logic          o_win_valid,
    output logic [DW-1:0] o_win_col,
    output logic [DW-1:0] o_win_row,
    output logic          o_busy,
    output logic          o_frame_done
);

    localparam logic [DW-1:0] W_MIN      = DW'(KERNEL + 1);
    localparam logic [DW-1:0] W_MAX      = DW'(MAX_WIDTH);
    localparam logic [DW-1:0] H_MIN      = DW'(KERNEL);
    localparam logic [DW-1:0] WIN_MIN    = DW'(KERNEL - 1);
    localparam logic [DW-1:0] PRIME_LAST = DW'(KERNEL - 2);
    localparam logic [DW-1:0] LEN_RESET  = DW'(MAX_WIDTH - 2);

    state_t        r_state;
    logic [DW-1:0] r_width;
    logic [DW-1:0] r_height;
    logic [DW-1:0] r_buff_len_ctrl;
    logic [DW-1:0] r_win_col;
    logic [DW-1:0] r_win_row;
    logic          r_cfg_ready;
    logic          r_cfg_err;
    logic          r_buff_len_rst;
    logic          r_win_valid;
    logic          r_busy;
    logic          r_frame_done;

    logic [DW-1:0] w_col;
    logic [DW-1:0] w_row;
    logic          w_col_wrap;
    logic          w_last;
    logic          w_active;
    logic          w_accept;
    logic          w_cfg_legal;
    logic          w_clr;
    logic          w_win_hit;

    assign w_active    = (r_state == StPrime) || (r_state == StRun);
    assign o_s_ready   = w_active & i_m_ready;
    assign o_shift_en  = i_s_valid & o_s_ready;
    assign w_accept    = o_shift_en;
    assign w_cfg_legal = (i_cfg_width >= W_MIN) && (i_cfg_width <= W_MAX) &&
                         (i_cfg_height >= H_MIN);
    // Counters sit at zero while idle so every frame starts at (0,0).
    assign w_clr       = (r_state == StIdle) || i_abort;
    assign w_win_hit   = w_accept && (w_row >= WIN_MIN) && (w_col >= WIN_MIN);

    row_col_counter #(
        .DW (DW)
    ) u_row_col_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_clr),
        .i_inc      (w_accept),
        .i_width    (r_width),
        .i_height   (r_height),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_col_wrap (w_col_wrap),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_width         <= '0;
            r_height        <= '0;
            r_buff_len_ctrl <= LEN_RESET;
            r_win_col       <= '0;
            r_win_row       <= '0;
            r_cfg_ready     <= 1'b1;
            r_cfg_err       <= 1'b0;
            r_buff_len_rst  <= 1'b0;
            r_win_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_cfg_err      <= 1'b0;
            r_buff_len_rst <= 1'b0;
            r_frame_done   <= 1'b0;
            r_win_valid    <= w_win_hit;
            if (w_win_hit) begin
                r_win_col <= w_col;
                r_win_row <= w_row;
            end
            if (i_abort && (r_state != StIdle)) begin
                r_state     <= StIdle;
                r_cfg_ready <= 1'b1;
                r_busy      <= 1'b0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_cfg_valid) begin
                            if (w_cfg_legal) begin
                                r_width         <= i_cfg_width;
                                r_height        <= i_cfg_height;
                                r_buff_len_ctrl <= i_cfg_width - DW'(2);
                                r_buff_len_rst  <= 1'b1;
                                r_cfg_ready     <= 1'b0;
                                r_busy          <= 1'b1;
                                r_state         <= StLoad;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    StLoad: r_state <= StPrime;
                    StPrime, StRun: begin
                        if (w_accept) begin
                            if (w_last) begin
                                r_state      <= StDone;
                                r_frame_done <= 1'b1;
                            end else if (w_col_wrap && (w_row == PRIME_LAST)) begin
                                r_state <= StRun;
                            end
                        end
                    end
                    StDone: begin
                        r_state     <= StIdle;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_cfg_ready     = r_cfg_ready;
    assign o_cfg_err       = r_cfg_err;
    assign o_buff_len_ctrl = r_buff_len_ctrl;
    assign o_buff_len_rst  = r_buff_len_rst;
    assign o_win_valid     = r_win_valid;
    assign o_win_col       = r_win_col;
    assign o_win_row       = r_win_row;
    assign o_busy          = r_busy;
    assign o_frame_done    = r_frame_done;

endmodule
